vote_window_timer: RTL



---
 rtl/evm_pkg.sv | 26 ++
 rtl/edge_sync.sv | 29 ++
 rtl/vote_window_timer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/evm_pkg.sv
// Shared types and defaults for the EVM voting-window timer.
// State encoding plus default window, pulse and timeout constants.
package evm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOCK,
    OPEN,
    DONE,
    FAULT
  } state_e;

  localparam int unsigned CNT_W_DEF        = 16;
  localparam int unsigned WINDOW_TICKS_DEF = 100;
  localparam int unsigned START_PULSE_DEF  = 5;
  localparam int unsigned LOCK_TIMEOUT_DEF = 64;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for async inputs.
// rise_pulse is high for one clk cycle per synchronised rising edge.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Sync chain; s3 holds the previous synchronised level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/vote_window_timer.sv
// Voting-window timer: starts the clock generator, times the window in gen_clk ticks.
// Optional VOTE_WINDOW_EXTEND_EN adds a one-shot ext_req window extension.
module vote_window_timer
  import evm_pkg::*;
#(
  parameter int unsigned WINDOW_TICKS = WINDOW_TICKS_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned START_PULSE  = START_PULSE_DEF,
  parameter int unsigned LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
`ifdef VOTE_WINDOW_EXTEND_EN
  ,
  parameter int unsigned EXT_TICKS    = 50
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             open_req,
  input  logic             close_req,
  input  logic             gen_clk,
`ifdef VOTE_WINDOW_EXTEND_EN
  input  logic             ext_req,
`endif
  output logic             strt_clk,
  output logic             window_open,
  output logic [CNT_W-1:0] ticks_left,
  output logic             expired,
  output logic             fault
);

  localparam int unsigned TMAX = max_u(START_PULSE, LOCK_TIMEOUT);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] dec;
  logic             tick;
  logic             last;
  logic             strt_q, strt_d;
  logic             win_q, win_d;
  logic             exp_q, exp_d;
  logic             flt_q, flt_d;

  edge_sync u_gen_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (gen_clk),
    .rise_pulse(tick)
  );

`ifdef VOTE_WINDOW_EXTEND_EN
  localparam int unsigned SW = CNT_W + 1;

  logic          ext_used_q;
  logic          ext_hit;
  logic [SW-1:0] ext_sum;

  assign ext_hit = ext_req & ~ext_used_q & (state_q == OPEN);
  assign ext_sum = {1'b0, left_q} + SW'(EXT_TICKS);
  assign base    = !ext_hit     ? left_q :
                   ext_sum[CNT_W] ? '1   : ext_sum[CNT_W-1:0];

  // One extension per session; re-armed when a new session starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_used_q <= 1'b0;
    end else if (state_d == START && state_q != START) begin
      ext_used_q <= 1'b0;
    end else if (ext_hit) begin
      ext_used_q <= 1'b1;
    end
  end
`else
  assign base = left_q;
`endif

  // Tick decrement blocked at zero; the 1->0 tick ends the window.
  assign dec  = (tick && base != '0) ? base - 1'b1 : base;
  assign last = tick && (base == CNT_W'(1));

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    unique case (state_q)
      IDLE, DONE, FAULT: begin
        if (open_req) begin
          state_d = START;
          cnt_d   = TW'(START_PULSE);
          left_d  = '0;
        end
      end
      START: begin
        if (cnt_q == TW'(1)) begin
          state_d = LOCK;
          cnt_d   = TW'(LOCK_TIMEOUT);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LOCK: begin
        if (tick) begin
          state_d = OPEN;
          left_d  = CNT_W'(WINDOW_TICKS);
        end else if (cnt_q == TW'(1)) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      OPEN: begin
        left_d = dec;
        if (last || close_req) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    strt_d = (state_d == START);
    win_d  = (state_d == OPEN);
    exp_d  = (state_d == DONE);
    flt_d  = (state_d == FAULT);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      left_q  <= '0;
      strt_q  <= 1'b0;
      win_q   <= 1'b0;
      exp_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      strt_q  <= strt_d;
      win_q   <= win_d;
      exp_q   <= exp_d;
      flt_q   <= flt_d;
    end
  end

  assign strt_clk    = strt_q;
  assign window_open = win_q;
  assign ticks_left  = left_q;
  assign expired     = exp_q;
  assign fault       = flt_q;

endmodule
